// File: rtl/ad_nios_adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// ad_nios_adc_sample_fifo
//   Avalon-MM slave that buffers ADC samples from the front-end capture logic
//   in a FIFO. The Nios CPU drains the FIFO by reading the DATA register. A
//   level/overflow interrupt means the CPU does not have to poll per sample.
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_sample_data   ADC sample, qualified by i_sample_valid
//   i_sample_valid  one-cycle push strobe
//   i_chipselect    Avalon slave select
//   i_address       0 DATA, 1 STATUS, 2 CONTROL, 3 THRESHOLD
//   i_read          Avalon read (qualified by chipselect)
//   i_write         Avalon write (qualified by chipselect)
//   i_writedata     Avalon write data
//   o_readdata      registered read data, read latency 1
//   o_irq           registered interrupt request, active high
// ---------------------------------------------------------------------------
module ad_nios_adc_sample_fifo #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int IRQ_LEVEL  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [DATA_W-1:0] i_sample_data,
  input  logic              i_sample_valid,
  input  logic              i_chipselect,
  input  logic [1:0]        i_address,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [31:0]       i_writedata,
  output logic [31:0]       o_readdata,
  output logic              o_irq
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0] THRESH_RST = CW'(IRQ_LEVEL);

  logic [DATA_W-1:0]     r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_enable;
  logic                  r_irq_en;
  logic [CW-1:0]         r_threshold;
  logic [31:0]           r_readdata;
  logic                  r_irq;

  logic                  w_rd;
  logic                  w_wr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ovf_event;
  logic                  w_flush;
  logic                  w_ovf_clr;
  logic [31:0]           w_head;
  logic [31:0]           w_status;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_rd    = i_chipselect & i_read;
  assign w_wr    = i_chipselect & i_write;
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);

  // A DATA read of an empty FIFO returns 0 and must not move the pointers.
  assign w_pop = w_rd & (i_address == 2'd0) & ~w_empty;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push      = r_enable & i_sample_valid & (~w_full | w_pop);
  assign w_ovf_event = r_enable & i_sample_valid & w_full & ~w_pop;

  assign w_flush   = w_wr & (i_address == 2'd2) & i_writedata[2];
  assign w_ovf_clr = w_wr & (i_address == 2'd1) & i_writedata[2];

  assign w_unused = &{1'b0, i_writedata[31:CW]};

  // Sample storage has no reset; contents are only meaningful below count.
  always_ff @(posedge i_clk) begin
    if (w_push && !w_flush) begin
      r_mem[r_wr_ptr] <= i_sample_data;
    end
  end

  // Pointer and occupancy tracking; flush overrides any push or pop.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Sticky overflow: a new overflow event beats a W1C clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_event) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // CONTROL and THRESHOLD registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_enable    <= 1'b0;
      r_irq_en    <= 1'b0;
      r_threshold <= THRESH_RST;
    end else if (w_wr) begin
      if (i_address == 2'd2) begin
        r_enable <= i_writedata[0];
        r_irq_en <= i_writedata[1];
      end
      if (i_address == 2'd3) begin
        r_threshold <= i_writedata[CW-1:0];
      end
    end
  end

  // Read mux; the head entry is zero-extended and an empty FIFO reads as 0.
  always_comb begin
    w_head = '0;
    if (!w_empty) begin
      w_head[DATA_W-1:0] = r_mem[r_rd_ptr];
    end
    w_status                 = '0;
    w_status[16 +: CW]       = r_count;
    w_status[2]              = r_overflow;
    w_status[1]              = w_full;
    w_status[0]              = w_empty;
    w_rdata = '0;
    case (i_address)
      2'd0:    w_rdata = w_head;
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = {30'd0, r_irq_en, r_enable};
      default: w_rdata = {{(32-CW){1'b0}}, r_threshold};
    endcase
  end

  // Read data holds its last value between reads.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_readdata <= '0;
    end else if (w_rd) begin
      r_readdata <= w_rdata;
    end
  end

  // Interrupt follows the register state one cycle late; THRESHOLD 0 disables the level term.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & (r_overflow | ((r_threshold != '0) && (r_count >= r_threshold)));
    end
  end

  assign o_readdata = r_readdata;
  assign o_irq      = r_irq;

endmodule

// File: tb/tb_ad_nios_adc_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_ad_nios_adc_sample_fifo
//   Self-checking bench for ad_nios_adc_sample_fifo. A queue holds the samples
//   the FIFO is expected to contain; DATA reads pop and compare against it.
// ---------------------------------------------------------------------------
module tb_ad_nios_adc_sample_fifo;

  logic        clk;
  logic        reset_n;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        chipselect;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  logic [15:0] q[$];
  bit          mEnable;
  int          nTests;
  int          nFail;

  ad_nios_adc_sample_fifo #(
    .DATA_W(16),
    .DEPTH_LOG2(4),
    .IRQ_LEVEL(8)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_sample_data(sample_data),
    .i_sample_valid(sample_valid),
    .i_chipselect(chipselect),
    .i_address(address),
    .i_read(read),
    .i_write(write),
    .i_writedata(writedata),
    .o_readdata(readdata),
    .o_irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus and stimulus helpers: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
    if (a == 2'd2) mEnable = d[0];
    if (a == 2'd2 && d[2]) q.delete();
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic pushSample(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1; sample_data = d;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    if (mEnable && q.size() < 16) q.push_back(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset_n = 1'b0;
    #22;
    nTests++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs readdata=%h irq=%b expected 0/0", readdata, irq);
    end
    @(negedge clk); reset_n = 1'b1;
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00000001) begin
      nFail++; $display("[TB] FAIL reset_status got %h expected 00000001", d);
    end
    busRead(2'd3, d);
    nTests++;
    if (d !== 32'h00000008) begin
      nFail++; $display("[TB] FAIL reset_threshold got %h expected 00000008", d);
    end
    busRead(2'd2, d);
    nTests++;
    if (d !== 32'h00000000) begin
      nFail++; $display("[TB] FAIL reset_control got %h expected 00000000", d);
    end
  endtask

  task automatic test_order;
    logic [31:0] d;
    logic [31:0] exp;
    busWrite(2'd2, 32'h1);
    pushSample(16'h0123);
    pushSample(16'h0456);
    pushSample(16'h0789);
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00030000) begin
      nFail++; $display("[TB] FAIL order_status3 got %h expected 00030000", d);
    end
    for (int i = 0; i < 4; i++) begin
      exp = (q.size() != 0) ? {16'h0, q.pop_front()} : 32'h0;
      busRead(2'd0, d);
      nTests++;
      if (d !== exp) begin
        nFail++; $display("[TB] FAIL order_data%0d got %h expected %h", i, d, exp);
      end
    end
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00000001) begin
      nFail++; $display("[TB] FAIL order_status_empty got %h expected 00000001", d);
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    logic [31:0] exp;
    for (int i = 0; i < 17; i++) pushSample(16'($urandom));
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00100006) begin
      nFail++; $display("[TB] FAIL ovf_status got %h expected 00100006", d);
    end
    busWrite(2'd1, 32'h4);
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00100002) begin
      nFail++; $display("[TB] FAIL ovf_w1c got %h expected 00100002", d);
    end
    nTests++;
    if (irq !== 1'b0) begin
      nFail++; $display("[TB] FAIL ovf_irq_disabled irq=%b expected 0", irq);
    end
    for (int i = 0; i < 16; i++) begin
      exp = {16'h0, q.pop_front()};
      busRead(2'd0, d);
      nTests++;
      if (d !== exp) begin
        nFail++; $display("[TB] FAIL ovf_drain%0d got %h expected %h", i, d, exp);
      end
    end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic [31:0] exp;
    busWrite(2'd3, 32'h4);
    busWrite(2'd2, 32'h3);
    for (int i = 0; i < 3; i++) begin
      pushSample(16'h1000 + 16'(i));
      idle(1);
      nTests++;
      if (irq !== 1'b0) begin
        nFail++; $display("[TB] FAIL irq_below%0d irq=%b expected 0", i, irq);
      end
    end
    pushSample(16'h1003);
    nTests++;
    if (irq !== 1'b0) begin
      nFail++; $display("[TB] FAIL irq_lag irq=%b expected 0", irq);
    end
    idle(1);
    nTests++;
    if (irq !== 1'b1) begin
      nFail++; $display("[TB] FAIL irq_level irq=%b expected 1", irq);
    end
    exp = {16'h0, q.pop_front()};
    busRead(2'd0, d);
    nTests++;
    if (d !== exp || irq !== 1'b1) begin
      nFail++; $display("[TB] FAIL irq_pop data=%h irq=%b expected %h/1", d, irq, exp);
    end
    idle(1);
    nTests++;
    if (irq !== 1'b0) begin
      nFail++; $display("[TB] FAIL irq_clear irq=%b expected 0", irq);
    end
    while (q.size() != 0) begin
      exp = {16'h0, q.pop_front()};
      busRead(2'd0, d);
      nTests++;
      if (d !== exp) begin
        nFail++; $display("[TB] FAIL irq_drain got %h expected %h", d, exp);
      end
    end
    busWrite(2'd3, 32'h8);
    busWrite(2'd2, 32'h1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) pushSample(16'h2000 + 16'(i));
    exp = {16'h0, q.pop_front()};
    @(negedge clk);
    sample_valid = 1'b1; sample_data = 16'hCAFE;
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    @(posedge clk); #1;
    sample_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    q.push_back(16'hCAFE);
    nTests++;
    if (readdata !== exp) begin
      nFail++; $display("[TB] FAIL b2b_full_data got %h expected %h", readdata, exp);
    end
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00100002) begin
      nFail++; $display("[TB] FAIL b2b_full_status got %h expected 00100002", d);
    end
    while (q.size() != 0) begin
      exp = {16'h0, q.pop_front()};
      busRead(2'd0, d);
      nTests++;
      if (d !== exp) begin
        nFail++; $display("[TB] FAIL b2b_drain got %h expected %h", d, exp);
      end
    end
    // Simultaneous push and read on an empty FIFO.
    @(negedge clk);
    sample_valid = 1'b1; sample_data = 16'h5A5A;
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    @(posedge clk); #1;
    sample_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    q.push_back(16'h5A5A);
    nTests++;
    if (readdata !== 32'h0) begin
      nFail++; $display("[TB] FAIL b2b_empty_data got %h expected 00000000", readdata);
    end
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00010000) begin
      nFail++; $display("[TB] FAIL b2b_empty_status got %h expected 00010000", d);
    end
    exp = {16'h0, q.pop_front()};
    busRead(2'd0, d);
    nTests++;
    if (d !== exp) begin
      nFail++; $display("[TB] FAIL b2b_empty_stored got %h expected %h", d, exp);
    end
  endtask

  task automatic test_flush;
    logic [31:0] d;
    pushSample(16'h3001);
    pushSample(16'h3002);
    @(negedge clk);
    sample_valid = 1'b1; sample_data = 16'hBEEF;
    chipselect = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h5;
    @(posedge clk); #1;
    sample_valid = 1'b0; chipselect = 1'b0; write = 1'b0;
    q.delete();
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00000001) begin
      nFail++; $display("[TB] FAIL flush_status got %h expected 00000001", d);
    end
    busRead(2'd2, d);
    nTests++;
    if (d !== 32'h00000001) begin
      nFail++; $display("[TB] FAIL flush_control got %h expected 00000001", d);
    end
    busRead(2'd0, d);
    nTests++;
    if (d !== 32'h0) begin
      nFail++; $display("[TB] FAIL flush_data got %h expected 00000000", d);
    end
    busWrite(2'd0, 32'h1234);
    busWrite(2'd2, 32'h0);
    pushSample(16'h4444);
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00000001) begin
      nFail++; $display("[TB] FAIL disabled_push got %h expected 00000001", d);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    busWrite(2'd2, 32'h3);
    for (int i = 0; i < 17; i++) pushSample(16'h6000 + 16'(i));
    idle(2);
    nTests++;
    if (irq !== 1'b1) begin
      nFail++; $display("[TB] FAIL ovf_irq irq=%b expected 1", irq);
    end
    @(negedge clk); reset_n = 1'b0;
    #1;
    q.delete(); mEnable = 1'b0;
    nTests++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin
      nFail++; $display("[TB] FAIL midreset_async irq=%b readdata=%h expected 0/0", irq, readdata);
    end
    @(negedge clk); reset_n = 1'b1;
    busRead(2'd1, d);
    nTests++;
    if (d !== 32'h00000001) begin
      nFail++; $display("[TB] FAIL midreset_status got %h expected 00000001", d);
    end
    busRead(2'd2, d);
    nTests++;
    if (d !== 32'h00000000) begin
      nFail++; $display("[TB] FAIL midreset_control got %h expected 00000000", d);
    end
  endtask

  // Scenario sequence.
  initial begin
    nTests = 0; nFail = 0; mEnable = 1'b0;
    sample_data = '0; sample_valid = 1'b0; chipselect = 1'b0;
    address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    test_reset();
    test_order();
    test_overflow();
    test_irq();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
